// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
//
// Multi-cycle WIDTH-bit adder, with WIDTH = 4*NIBBLES. It accepts one operand
// pair over a valid/ready handshake. It then feeds the operands one nibble per
// clock, LSB first, through a single adder4b instance. The carry between
// nibbles is held in a register. A wide add therefore costs one 4-bit adder
// plus sequencing logic.
//
// Optional build macro:
//   NIBBLE_SERIAL_ADDER_OVF_EN - adds out_ovf, the signed two's-complement
//                                overflow of the WIDTH-bit add. It is captured
//                                together with out_sum.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands presented
//   in_ready   block can accept operands (IDLE only)
//   in_a       operand A            [WIDTH-1:0]
//   in_b       operand B            [WIDTH-1:0]
//   in_cin     carry-in to nibble 0
//   out_valid  result available (DONE)
//   out_ready  consumer accepts result
//   out_sum    registered sum       [WIDTH-1:0]
//   out_cout   carry-out of top nibble
//   busy       high in RUN or DONE
//   out_ovf    signed overflow (only with NIBBLE_SERIAL_ADDER_OVF_EN)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// adder4b: plain combinational 4-bit adder with carry-in and carry-out.
//   a, b   addends
//   c_in   carry-in
//   S      4-bit sum
//   C4     carry-out
// ---------------------------------------------------------------------------
module adder4b (
  output logic [3:0] S,
  output logic       C4,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in
);

  assign {C4, S} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};

endmodule

// ---------------------------------------------------------------------------
// FSM states:
//   state | meaning
//   IDLE  | in_ready=1, waiting for operands
//   RUN   | one nibble added per clock, idx selects the slice
//   DONE  | out_valid=1, result held until out_ready
// ---------------------------------------------------------------------------
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic                 in_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_sum,
  output logic                 out_cout,
  output logic                 busy
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic                 out_ovf
`endif
);

  localparam int WIDTH = 4 * NIBBLES;
  // A single-nibble build still needs a 1-bit index so that all the
  // compares stay well formed.
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;
  logic             carry_reg;
  logic [IDX_W-1:0] idx;
  logic             idx_last;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] nib_s;
  logic       nib_c4;

  // --------------------------------------------------------------------------
  // Nibble select. This is a decoded mux rather than a variable part-select,
  // so every index stays in range for any NIBBLES value.
  // --------------------------------------------------------------------------
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        nib_a = op_a[4*i +: 4];
        nib_b = op_b[4*i +: 4];
      end
    end
  end

  adder4b u_adder4b (
    .S    (nib_s),
    .C4   (nib_c4),
    .a    (nib_a),
    .b    (nib_b),
    .c_in (carry_reg)
  );

  // The work vector with the current nibble already merged in. On the last
  // nibble this is the complete sum, which lets out_sum load in the same edge.
  always_comb begin
    work_next = work;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        work_next[4*i +: 4] = nib_s;
      end
    end
  end

  assign idx_last = (idx == IDX_LAST);

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  // The carry into the MSB can be recovered from the top nibble's sum bit:
  // c_in3 = a3 ^ b3 ^ s3. Overflow is then c_in3 ^ c_out3.
  logic ovf_nib;
  assign ovf_nib = (nib_a[3] ^ nib_b[3] ^ nib_s[3]) ^ nib_c4;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (idx_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      work      <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a      <= in_a;
            op_b      <= in_b;
            carry_reg <= in_cin;
            idx       <= '0;
          end
        end
        RUN: begin
          work      <= work_next;
          carry_reg <= nib_c4;
          // idx stops at the last slice instead of wrapping.
          if (idx_last) begin
            out_sum  <= work_next;
            out_cout <= nib_c4;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ovf <= 1'b0;
    end else if (state == RUN && idx_last) begin
      out_ovf <= ovf_nib;
    end
  end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // NIBBLES=4 instance
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        busy;
  logic        out_ovf;

  // NIBBLES=1 instance
  logic       d1_in_valid = 1'b0;
  logic       d1_in_ready;
  logic [3:0] d1_in_a = '0;
  logic [3:0] d1_in_b = '0;
  logic       d1_in_cin = 1'b0;
  logic       d1_out_valid;
  logic       d1_out_ready = 1'b1;
  logic [3:0] d1_out_sum;
  logic       d1_out_cout;
  logic       d1_busy;
  logic       d1_out_ovf;

  nibble_serial_adder #(.NIBBLES(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (d1_in_valid),
    .in_ready  (d1_in_ready),
    .in_a      (d1_in_a),
    .in_b      (d1_in_b),
    .in_cin    (d1_in_cin),
    .out_valid (d1_out_valid),
    .out_ready (d1_out_ready),
    .out_sum   (d1_out_sum),
    .out_cout  (d1_out_cout),
    .busy      (d1_busy)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .out_ovf   (d1_out_ovf)
`endif
  );

`ifndef NIBBLE_SERIAL_ADDER_OVF_EN
  assign out_ovf    = 1'b0;
  assign d1_out_ovf = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];
  exp_t sb1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (out_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("latency", 32'(cyc - sb[0].acc_cyc), 32'd4);
      end
    end
    if (out_valid && out_ready && sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("sum", 32'(out_sum), 32'(e.sum));
      chk("cout", 32'(out_cout), 32'(e.cout));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      chk("ovf", 32'(out_ovf), 32'(e.ovf));
`endif
    end
    prev_valid = out_valid;
  end

  logic prev_valid1 = 1'b0;
  always @(negedge clk) begin
    if (d1_out_valid && !prev_valid1) begin
      if (sb1.size() == 0) begin
        chk("n1_unexpected_out_valid", 32'(d1_out_valid), 32'd0);
      end else begin
        chk("n1_latency", 32'(cyc - sb1[0].acc_cyc), 32'd1);
      end
    end
    if (d1_out_valid && d1_out_ready && sb1.size() != 0) begin
      exp_t e;
      e = sb1.pop_front();
      chk("n1_sum", 32'(d1_out_sum), 32'(e.sum));
      chk("n1_cout", 32'(d1_out_cout), 32'(e.cout));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      chk("n1_ovf", 32'(d1_out_ovf), 32'(e.ovf));
`endif
    end
    prev_valid1 = d1_out_valid;
  end

  // ---------------- drivers ----------------
  // Presents one operand pair and pushes the expected result at the accepting
  // edge. hold>0 keeps in_valid high with junk operands during RUN.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [15:0] e_sum, input logic e_cout, input logic e_ovf,
                      input int hold);
    exp_t e;
    int n;
    @(negedge clk);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    n = 0;
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    e.sum = e_sum; e.cout = e_cout; e.ovf = e_ovf; e.acc_cyc = cyc;
    sb.push_back(e);
    if (hold > 0) begin
      in_a = 16'hDEAD; in_b = 16'hBEEF; in_cin = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send1(input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [3:0] e_sum, input logic e_cout, input logic e_ovf);
    exp_t e;
    int n;
    @(negedge clk);
    d1_in_a = a; d1_in_b = b; d1_in_cin = c; d1_in_valid = 1'b1;
    n = 0;
    while (!d1_in_ready) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        chk("n1_in_ready_timeout", 32'(d1_in_ready), 32'd1);
        d1_in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    e.sum = {12'h000, e_sum}; e.cout = e_cout; e.ovf = e_ovf; e.acc_cyc = cyc;
    sb1.push_back(e);
    d1_in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || sb1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_cout", 32'(out_cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
    send(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
    send(16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0, 0);
    send(16'h1234, 16'hEDCB, 1'b1, 16'h0000, 1'b1, 1'b0, 3);
    send(16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0, 0);
    send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    wait_drain();

    // Backpressure
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_sum", 32'(out_sum), 32'h3333);
      chk("bp_cout", 32'(out_cout), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_rel_in_ready", 32'(in_ready), 32'd1);
    chk("bp_rel_out_valid", 32'(out_valid), 32'd0);
    chk("bp_rel_busy", 32'(busy), 32'd0);
    chk("bp_hold_sum_idle", 32'(out_sum), 32'h3333);

    // Reset while RUN at idx=2
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_busy_before", 32'(busy), 32'd1);
    chk("mid_sum_before", 32'(out_sum), 32'h3333);
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("mid_rst_sum", 32'(out_sum), 32'd0);
    chk("mid_rst_cout", 32'(out_cout), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);
    wait_drain();

    // Single-nibble instance
    send1(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
    send1(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
    send1(4'h5, 4'h9, 1'b1, 4'hF, 1'b0, 1'b0);
    wait_drain();

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("sb1_empty", 32'(sb1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
